// File: rtl/mmu_request_arbiter.sv
// N-core round-robin front end for one MMU port: one registered request slot,
// an in-order tag FIFO of granted core IDs, and combinational response steering.
module mmu_request_arbiter #(
  parameter int NUM_CORES       = 4,
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                   clk_in,
  input  logic                                   rst_in,
  input  logic [NUM_CORES-1:0]                   core_request_valid_in,
  output logic [NUM_CORES-1:0]                   core_request_ready_out,
  input  logic [NUM_CORES*ADDR_WIDTH-1:0]        core_request_address_in,
  input  logic [NUM_CORES-1:0]                   core_request_operation_in,
  input  logic [NUM_CORES*DATA_WIDTH-1:0]        core_request_data_in,
  output logic [NUM_CORES-1:0]                   core_response_valid_out,
  input  logic [NUM_CORES-1:0]                   core_response_ready_in,
  output logic [DATA_WIDTH-1:0]                  core_response_data_out,
  output logic                                   mmu_request_valid_out,
  input  logic                                   mmu_request_ready_in,
  output logic [ADDR_WIDTH-1:0]                  mmu_request_address_out,
  output logic                                   mmu_request_operation_out,
  output logic [DATA_WIDTH-1:0]                  mmu_request_data_out,
  input  logic                                   mmu_response_valid_in,
  output logic                                   mmu_response_ready_out,
  input  logic [DATA_WIDTH-1:0]                  mmu_response_data_in,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_count_out,
  output logic                                   orphan_response_out
);

  localparam int IW = $clog2(NUM_CORES);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int CW = $clog2(MAX_OUTSTANDING+1);

  logic                  req_valid_q;
  logic [ADDR_WIDTH-1:0] req_addr_q;
  logic                  req_op_q;
  logic [DATA_WIDTH-1:0] req_data_q;
  logic [IW-1:0]         last_grant_q;
  logic [IW-1:0]         tag_q [MAX_OUTSTANDING];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;
  logic                  orphan_q;

  logic                  found, can_grant, push, pop, fifo_empty;
  logic [IW-1:0]         grant_idx, head;
  int unsigned           cand;

  // Rotating priority: first valid core after the last actual grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_CORES; k++) begin
      cand = (32'(last_grant_q) + k) % NUM_CORES;
      if (!found && core_request_valid_in[IW'(cand)]) begin
        found     = 1'b1;
        grant_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    can_grant  = !rst_in && (!req_valid_q || mmu_request_ready_in) &&
                 (count_q < CW'(MAX_OUTSTANDING));
    push       = found && can_grant;
    core_request_ready_out = push ? (NUM_CORES'(1) << grant_idx) : '0;

    fifo_empty = (count_q == '0);
    head       = tag_q[rd_ptr_q];
    mmu_response_ready_out  = !fifo_empty && core_response_ready_in[head];
    core_response_valid_out = (mmu_response_valid_in && !fifo_empty) ?
                              (NUM_CORES'(1) << head) : '0;
    core_response_data_out  = mmu_response_data_in;
    pop        = mmu_response_valid_in && mmu_response_ready_out;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      req_valid_q  <= 1'b0;
      req_addr_q   <= '0;
      req_op_q     <= 1'b0;
      req_data_q   <= '0;
      last_grant_q <= IW'(NUM_CORES-1);
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) tag_q[i] <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      orphan_q     <= 1'b0;
    end else begin
      if (push) begin
        req_valid_q     <= 1'b1;
        req_addr_q      <= core_request_address_in[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
        req_op_q        <= core_request_operation_in[grant_idx];
        req_data_q      <= core_request_data_in[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        last_grant_q    <= grant_idx;
        tag_q[wr_ptr_q] <= grant_idx;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end else if (mmu_request_ready_in) begin
        req_valid_q <= 1'b0;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
      if (mmu_response_valid_in && fifo_empty) orphan_q <= 1'b1;
    end
  end

  assign mmu_request_valid_out     = req_valid_q;
  assign mmu_request_address_out   = req_addr_q;
  assign mmu_request_operation_out = req_op_q;
  assign mmu_request_data_out      = req_data_q;
  assign outstanding_count_out     = count_q;
  assign orphan_response_out       = orphan_q;

endmodule

// File: tb/tb_mmu_request_arbiter.sv
// Bench for mmu_request_arbiter: directed scenarios plus random traffic checked
// against a queue-based transaction model.
module tb_mmu_request_arbiter;
  localparam int NC = 4, AW = 32, DW = 32, MO = 4, CW = $clog2(MO+1);

  logic clk = 1'b0, rst;
  logic [NC-1:0]    req_v, req_rdy, req_op, rsp_v, rsp_rdy;
  logic [NC*AW-1:0] req_addr;
  logic [NC*DW-1:0] req_data;
  logic [DW-1:0]    rsp_data;
  logic             m_req_v, m_req_rdy, m_req_op;
  logic [AW-1:0]    m_req_addr;
  logic [DW-1:0]    m_req_data;
  logic             m_rsp_v, m_rsp_rdy;
  logic [DW-1:0]    m_rsp_data;
  logic [CW-1:0]    count;
  logic             orphan;

  always #5 clk = ~clk;

  mmu_request_arbiter #(.NUM_CORES(NC), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clk_in(clk), .rst_in(rst),
    .core_request_valid_in(req_v), .core_request_ready_out(req_rdy),
    .core_request_address_in(req_addr), .core_request_operation_in(req_op),
    .core_request_data_in(req_data),
    .core_response_valid_out(rsp_v), .core_response_ready_in(rsp_rdy),
    .core_response_data_out(rsp_data),
    .mmu_request_valid_out(m_req_v), .mmu_request_ready_in(m_req_rdy),
    .mmu_request_address_out(m_req_addr), .mmu_request_operation_out(m_req_op),
    .mmu_request_data_out(m_req_data),
    .mmu_response_valid_in(m_rsp_v), .mmu_response_ready_out(m_rsp_rdy),
    .mmu_response_data_in(m_rsp_data),
    .outstanding_count_out(count), .orphan_response_out(orphan)
  );

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model: priority pointer, queue of outstanding core IDs,
  // contents of the single request slot, sticky orphan flag.
  int            last_g;
  int            tags[$];
  bit            e_valid, e_op, e_orphan;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  logic [NC-1:0] dut_log[$];

  task automatic model_reset();
    last_g = NC-1; tags.delete(); e_valid = 0; e_op = 0;
    e_addr = '0; e_data = '0; e_orphan = 0;
  endtask

  // Called at posedge+1 with inputs set; checks before the edge, then advances.
  task automatic tick();
    int g, c;
    bit pop, exp_mrdy;
    logic [NC-1:0] exp_rdy, exp_rv;
    #3;
    g = -1;
    if ((!e_valid || m_req_rdy) && tags.size() < MO)
      for (int k = 1; k <= NC; k++) begin
        c = (last_g + k) % NC;
        if (g < 0 && req_v[c]) g = c;
      end
    exp_rdy = (g >= 0) ? (NC'(1) << g) : '0;
    exp_rv = '0; exp_mrdy = 0;
    if (tags.size() > 0) begin
      if (m_rsp_v) exp_rv[tags[0]] = 1'b1;
      exp_mrdy = rsp_rdy[tags[0]];
    end
    pop = m_rsp_v && exp_mrdy;
    check_eq("req_ready", req_rdy, exp_rdy);
    check_eq("mmu_req_valid", m_req_v, e_valid);
    if (e_valid) begin
      check_eq("mmu_req_addr", m_req_addr, e_addr);
      check_eq("mmu_req_op", m_req_op, e_op);
      check_eq("mmu_req_data", m_req_data, e_data);
    end
    check_eq("count", count, tags.size());
    check_eq("rsp_valid", rsp_v, exp_rv);
    check_eq("rsp_data", rsp_data, m_rsp_data);
    check_eq("mmu_rsp_ready", m_rsp_rdy, exp_mrdy);
    check_eq("orphan", orphan, e_orphan);
    if (req_rdy != '0) dut_log.push_back(req_rdy);
    @(posedge clk);
    if (m_rsp_v && tags.size() == 0) e_orphan = 1;
    if (pop) void'(tags.pop_front());
    if (g >= 0) begin
      tags.push_back(g); last_g = g; e_valid = 1;
      e_addr = req_addr[g*AW +: AW]; e_op = req_op[g]; e_data = req_data[g*DW +: DW];
    end else if (m_req_rdy) begin
      e_valid = 0;
    end
    #1;
  endtask

  task automatic set_fixed_fields();
    for (int i = 0; i < NC; i++) begin
      req_addr[i*AW +: AW] = AW'(32'h1000 * (i+1));
      req_data[i*DW +: DW] = DW'(32'hA000 + i);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_req_rdy"}, req_rdy, '0);
    check_eq({tag, "_mreq_v"}, m_req_v, 0);
    check_eq({tag, "_mreq_addr"}, m_req_addr, '0);
    check_eq({tag, "_mreq_op"}, m_req_op, 0);
    check_eq({tag, "_mreq_data"}, m_req_data, '0);
    check_eq({tag, "_count"}, count, 0);
    check_eq({tag, "_rsp_v"}, rsp_v, '0);
    check_eq({tag, "_mrsp_rdy"}, m_rsp_rdy, 0);
    check_eq({tag, "_orphan"}, orphan, 0);
  endtask

  task automatic drain();
    req_v = '0; rsp_rdy = '1;
    for (int i = 0; i < 20 && (tags.size() > 0 || e_valid); i++) begin
      m_rsp_v = (tags.size() > 0); m_rsp_data = $urandom; tick();
    end
    m_rsp_v = 0;
    check_eq("drained_count", count, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1);
  end

  initial begin
    rst = 1; req_v = '0; req_op = '0; req_addr = '0; req_data = '0; rsp_rdy = '0;
    m_req_rdy = 0; m_rsp_v = 0; m_rsp_data = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    req_v = '1;
    #1 check_reset_outputs("por");
    rst = 0; req_v = '0;
    set_fixed_fields();

    // Fairness with all cores requesting and MMU always ready/responding.
    dut_log.delete();
    req_v = '1; m_req_rdy = 1; rsp_rdy = '1;
    for (int i = 0; i < 12; i++) begin
      m_rsp_v = (tags.size() > 0); m_rsp_data = $urandom; tick();
    end
    check_eq("rr_len_ok", dut_log.size() >= 8, 1);
    for (int k = 0; k < 8 && k < dut_log.size(); k++)
      check_eq("rr_order", dut_log[k], NC'(1) << (k % NC));

    // Fill the tag FIFO with no responses.
    m_rsp_v = 0;
    for (int i = 0; i < 6; i++) tick();
    #1;
    check_eq("full_count", count, MO);
    check_eq("full_no_grant", req_rdy, '0);
    m_rsp_v = 1; m_rsp_data = 32'h55; tick();
    m_rsp_v = 0;
    #1 check_eq("grant_resumes", |req_rdy, 1);
    tick();
    drain();

    // Response routing: core 2 write, core 0 read, core 3 read.
    req_data[2*DW +: DW] = 32'hDEADBEEF;
    req_op = 4'b0100; req_v = 4'b0100; tick();
    req_op = 4'b0000; req_v = 4'b0001; tick();
    req_v = 4'b1000; tick();
    req_v = '0; tick();
    check_eq("route_count", count, 3);
    for (int i = 0; i < 3; i++) begin
      logic [NC-1:0] exp_vec [3];
      exp_vec[0] = 4'b0100; exp_vec[1] = 4'b0001; exp_vec[2] = 4'b1000;
      m_rsp_v = 1; m_rsp_data = DW'(i + 1);
      #1;
      check_eq("route_valid", rsp_v, exp_vec[i]);
      check_eq("route_data", rsp_data, DW'(i + 1));
      tick();
    end
    m_rsp_v = 0;
    set_fixed_fields();

    // Backpressure from core 2.
    req_v = 4'b0100; tick();
    req_v = '0; tick();
    m_rsp_v = 1; m_rsp_data = 32'h77; rsp_rdy = 4'b1011;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_ready_low", m_rsp_rdy, 0);
      check_eq("bp_head_held", rsp_v, 4'b0100);
      tick();
    end
    rsp_rdy = '1;
    #1 check_eq("bp_ready_rise", m_rsp_rdy, 1);
    tick();
    m_rsp_v = 0;
    check_eq("bp_popped", count, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      req_v = NC'($urandom); req_op = NC'($urandom); rsp_rdy = NC'($urandom);
      for (int c = 0; c < NC; c++) begin
        req_addr[c*AW +: AW] = $urandom;
        req_data[c*DW +: DW] = $urandom;
      end
      m_req_rdy = ($urandom_range(3, 0) != 0);
      m_rsp_v = (tags.size() > 0) && ($urandom_range(1, 0) == 1);
      m_rsp_data = $urandom;
      tick();
    end
    m_req_rdy = 1; m_rsp_v = 0;
    drain();

    // Asynchronous reset with three tags outstanding.
    set_fixed_fields();
    req_v = '1; m_rsp_v = 0; m_req_rdy = 1;
    for (int i = 0; i < 10 && tags.size() < 3; i++) tick();
    check_eq("pre_reset_count", count, 3);
    #1 rst = 1;
    #1 check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk); #1 rst = 0;
    #1 check_eq("first_grant_core0", req_rdy, 4'b0001);
    tick();
    drain();

    // Orphan response with an empty FIFO.
    req_v = '0; m_rsp_v = 1; m_rsp_data = 32'h99;
    #1;
    check_eq("orphan_no_valid", rsp_v, '0);
    check_eq("orphan_no_ready", m_rsp_rdy, 0);
    tick();
    m_rsp_v = 0;
    for (int i = 0; i < 3; i++) tick();
    check_eq("orphan_sticky", orphan, 1);
    rst = 1;
    #1 check_eq("orphan_cleared", orphan, 0);
    model_reset();
    @(posedge clk); #1 rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmu_request_arbiter.md
# mmu_request_arbiter

Parametrised N-core front end for a single MMU port (instruction_mmu or data_mmu) in the multicore build. Each core has its own valid/ready request and response channel. The block arbitrates requests round-robin onto one registered MMU request channel. It records the requesting core's ID in an in-order tag FIFO and steers each MMU response back to that core. It generalises the single-core fetch/cpu request–response handshake to NUM_CORES channels with bounded outstanding transactions.

## Interface
- NUM_CORES, 4, requesting cores (≥2)
- ADDR_WIDTH, 32, request address width
- DATA_WIDTH, 32, request/response data width
- MAX_OUTSTANDING, 4, tag FIFO depth (power of two, ≥2)
- Clock and reset: one clock; reset is asynchronous and active-high (clk_in, rst_in).
- clk_in  in  1  system clock
- rst_in  in  1  asynchronous active-high reset
- core_request_valid_in  in  NUM_CORES  per-core request valid
- core_request_ready_out  out  NUM_CORES  per-core grant; one-hot or zero
- core_request_address_in  in  NUM_CORES*ADDR_WIDTH  packed; core i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- core_request_operation_in  in  NUM_CORES  0 = read, 1 = write
- core_request_data_in  in  NUM_CORES*DATA_WIDTH  packed write data
- core_response_valid_out  out  NUM_CORES  per-core response valid; one-hot or zero
- core_response_ready_in  in  NUM_CORES  per-core response ready
- core_response_data_out  out  DATA_WIDTH  response data, shared by all cores
- mmu_request_valid_out / mmu_request_ready_in  out / in  1  MMU request handshake
- mmu_request_address_out, mmu_request_operation_out, mmu_request_data_out  out  ADDR_WIDTH, 1, DATA_WIDTH  registered request
- mmu_response_valid_in / mmu_response_ready_out  in / out  1  MMU response handshake
- mmu_response_data_in  in  DATA_WIDTH  MMU response data
- outstanding_count_out  out  $clog2(MAX_OUTSTANDING+1)  tags currently in FIFO
- orphan_response_out  out  1  sticky: MMU response seen with FIFO empty

## Operation
- Every request, read or write, receives exactly one MMU response. The MMU returns responses in request order.
- Request register (one entry) drives mmu_request_*. It is free when empty, or when mmu_request_valid_out & mmu_request_ready_in this cycle.
- Grant is allowed iff the register is free and outstanding_count_out < MAX_OUTSTANDING. Push-while-full is never granted, even with a simultaneous pop.
- Round-robin search starts at (last_grant+1) mod NUM_CORES and picks the first core with valid asserted. core_request_ready_out for that core only; combinational from valids, last_grant, register state and count.
- On handshake: capture that core's address, operation and data into the register; set mmu_request_valid_out; push the core index into the tag FIFO; update last_grant to that core.
- last_grant advances only on an actual handshake. An idle cycle keeps priority.
- Response path is combinational pass-through.
  - head = FIFO head tag.
  - core_response_valid_out[head] = mmu_response_valid_in & !empty.
  - core_response_data_out = mmu_response_data_in.
  - mmu_response_ready_out = !empty & core_response_ready_in[head].
- Pop on mmu_response_valid_in & mmu_response_ready_out.
- Same-cycle push and pop leave the count unchanged. Read and write pointers wrap modulo MAX_OUTSTANDING.
- If mmu_response_valid_in is asserted while the FIFO is empty: mmu_response_ready_out stays 0, no core_response_valid_out is asserted, and orphan_response_out sets and holds until reset.
- A held request must stay stable; the block does not revalidate it. Deasserting valid before grant simply removes the core from arbitration.

## Timing
- Reset values: all *_valid_out, core_request_ready_out, mmu_response_ready_out, mmu_request_* data, outstanding_count_out and orphan_response_out are 0. FIFO empty. last_grant = NUM_CORES-1, so core 0 has first priority.
- Request latency: core handshake in cycle t gives mmu_request_valid_out = 1 with the captured fields from t+1.
- Throughput: one request per cycle while mmu_request_ready_in stays high and the FIFO is not full.
- Response latency: 0 cycles, combinational from mmu_response_* to core_response_*.
- outstanding_count_out updates on the clock edge after a push or pop.
- Reset asserted mid-operation clears the register, the FIFO and the orphan flag immediately, with no clock required. The MMU shares rst_in, so in-flight transactions are abandoned.
- mmu_request_* fields hold while valid is high and ready is low.

## Test plan
- Reset: assert rst_in mid-burst with 3 tags outstanding -> all outputs 0 asynchronously, count 0; first grant after release goes to core 0.
- Fairness: cores 0–3 request continuously, MMU always ready -> grant order 0,1,2,3,0,1…; mmu_request_address_out matches each core's address one cycle after its grant.
- Full FIFO: MAX_OUTSTANDING=4, no MMU responses -> 4 requests issued, then core_request_ready_out = 0 and count = 4. One response pops, and next cycle a grant resumes.
- Response routing: issue core 2 (write, data 0xDEADBEEF), core 0 (read), core 3 (read); MMU returns 0x1, 0x2, 0x3 -> core_response_valid_out = 0b0100, 0b0001, 0b1000 in order, with that data.
- Backpressure: core 2 holds core_response_ready_in = 0 for 5 cycles -> mmu_response_ready_out = 0 and FIFO head unchanged; pops on the cycle ready rises.
- Orphan: mmu_response_valid_in = 1 with empty FIFO -> no core valid, ready_out = 0, orphan_response_out = 1 until reset.
